// File: rtl/bus_memory_responder_pkg.sv
// Shared constants for the bus memory responder: data/address bus width and FSM state codes.
package bus_memory_responder_pkg;

  localparam int unsigned BusWidth = 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StAck  = 2'd2;
  localparam logic [1:0] StHold = 2'd3;

endpackage

// File: rtl/sync_ram_8.sv
// Single-port 8-bit RAM: synchronous write, registered read with reset-cleared output register.
module sync_ram_8
  import bus_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [BusWidth-1:0] addr,
  input  logic [BusWidth-1:0] wdata,
  output logic [BusWidth-1:0] rdata
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BusWidth-1:0] mem [DEPTH];
  logic                in_range;
  logic [AddrW-1:0]    idx;

  // Out-of-range addresses never alias onto the implemented words.
  assign in_range = 32'(addr) < DEPTH;
  assign idx      = addr[AddrW-1:0];

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= in_range ? mem[idx] : '0;
    end
  end

endmodule

// File: rtl/bus_memory_responder.sv
// Wait-state memory responder: four-phase Mem_Rd/Mem_Wr handshake with a preload port and
// illegal-request detection, backed by sync_ram_8.
module bus_memory_responder
  import bus_memory_responder_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DEPTH       = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BusWidth-1:0] Address_Bus,
  input  logic [BusWidth-1:0] Data_Bus_Out,
  input  logic                Mem_Rd,
  input  logic                Mem_Wr,
  input  logic                Load_En,
  input  logic [BusWidth-1:0] Load_Addr,
  input  logic [BusWidth-1:0] Load_Data,
  output logic [BusWidth-1:0] Data_Bus_In,
  output logic                Mem_Ready,
  output logic                Bus_Err
);

  logic [1:0]          state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [BusWidth-1:0] addr_q, wdata_q;
  logic                wr_q;
  logic                ready_q, ready_d;
  logic                err_q, err_d;
  logic                capture, access, load_ok, strobe_held;
  logic                ram_we, ram_re;
  logic [BusWidth-1:0] ram_addr, ram_wdata;

  // Only the strobe that opened the transaction can close it.
  assign strobe_held = wr_q ? Mem_Wr : Mem_Rd;
  assign load_ok     = (state_q == StIdle) && !Mem_Rd && !Mem_Wr && Load_En;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    capture = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Mem_Rd && Mem_Wr) begin
          err_d   = 1'b1;
          state_d = StHold;
        end else if (Mem_Rd || Mem_Wr) begin
          capture = 1'b1;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          ready_d = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        if (!strobe_held) begin
          ready_d = 1'b0;
          state_d = StIdle;
        end
      end
      StHold: begin
        if (!Mem_Rd && !Mem_Wr) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      if (capture) begin
        addr_q  <= Address_Bus;
        wdata_q <= Data_Bus_Out;
        wr_q    <= Mem_Wr;
      end
    end
  end

  // Bus access and preload are mutually exclusive by FSM state, so one port suffices.
  assign ram_we    = (access && wr_q) || load_ok;
  assign ram_re    = access && !wr_q;
  assign ram_addr  = load_ok ? Load_Addr : addr_q;
  assign ram_wdata = load_ok ? Load_Data : wdata_q;

  sync_ram_8 #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (Data_Bus_In)
  );

  assign Mem_Ready = ready_q;
  assign Bus_Err   = err_q;

endmodule
